// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Byte-receive handshake and instruction-memory write port.
// Revision    : 1.0  initial release
// ============================================================================
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 7
) ();
  logic [7:0]            rxData;
  logic                  rxValid;
  logic                  rxReady;
  logic                  imemWE;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic [15:0]           imemData;

  // master = loader side, slave = receiver/memory side
  modport master (
    input  rxData, rxValid,
    output rxReady, imemWE, imemAddr, imemData
  );
  modport slave (
    output rxData, rxValid,
    input  rxReady, imemWE, imemAddr, imemData
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Framed byte-stream boot loader into instruction memory.
// Revision    : 1.0  initial release
// ============================================================================
module prog_loader #(
  parameter int         ADDR_WIDTH = 7,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.master bus,
  output logic         cpuRst,
  output logic         busy,
  output logic         loadOk,
  output logic         loadErr
);
  // Counter width must hold both a full LEN byte and a word count of 2^ADDR_WIDTH.
  localparam int              CW      = (ADDR_WIDTH + 1 > 8) ? ADDR_WIDTH + 1 : 8;
  localparam logic [CW-1:0]   MAX_LEN = CW'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_WR   = 3'd4,
    S_SUM  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [7:0]            sum_q, sum_d;
  logic [15:0]           data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, busy_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;

  logic                  w_xfer;
  logic [CW-1:0]         w_idx_inc;
  logic [CW-1:0]         w_byte_ext;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    data_d     = data_q;
    addr_d     = addr_q;
    cpu_rst_d  = cpu_rst_q;
    ok_d       = ok_q;
    err_d      = err_q;
    w_xfer     = bus.rxValid && ready_q;
    w_idx_inc  = idx_q + CW'(1);
    w_byte_ext = CW'(bus.rxData);

    case (state_q)
      S_IDLE: begin
        if (w_xfer && bus.rxData == SYNC_BYTE) begin
          state_d   = S_LEN;
          ok_d      = 1'b0;
          err_d     = 1'b0;
          cpu_rst_d = 1'b1;
        end
      end
      S_LEN: begin
        if (w_xfer) begin
          len_d = w_byte_ext;
          idx_d = '0;
          sum_d = '0;
          if (w_byte_ext == '0 || w_byte_ext > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (w_xfer) begin
          data_d[15:8] = bus.rxData;
          sum_d        = sum_q + bus.rxData;
          state_d      = S_LO;
        end
      end
      S_LO: begin
        if (w_xfer) begin
          data_d[7:0] = bus.rxData;
          sum_d       = sum_q + bus.rxData;
          addr_d      = idx_q[ADDR_WIDTH-1:0];
          state_d     = S_WR;
        end
      end
      S_WR: begin
        idx_d   = w_idx_inc;
        state_d = (w_idx_inc == len_q) ? S_SUM : S_HI;
      end
      S_SUM: begin
        if (w_xfer) begin
          if (bus.rxData == sum_q) begin
            ok_d      = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            err_d     = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_d = (state_d != S_WR);
    we_d    = (state_d == S_WR);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign bus.rxReady  = ready_q;
  assign bus.imemWE   = we_q;
  assign bus.imemAddr = addr_q;
  assign bus.imemData = data_q;
  assign cpuRst       = cpu_rst_q;
  assign busy         = busy_q;
  assign loadOk       = ok_q;
  assign loadErr      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader with a frame-level model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst;
  logic cpuRst, busy, loadOk, loadErr;

  prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

  prog_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpuRst  (cpuRst),
    .busy    (busy),
    .loadOk  (loadOk),
    .loadErr (loadErr)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total    = 0;
  int          cyc      = 0;
  logic        prev_rst = 1'b1;
  logic [22:0] obs_w[$];
  logic [22:0] exp_w[$];
  bit          exp_ok, exp_err;
  logic [7:0]  fr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_rst <= rst;
  end

  // Write capture, plus the invariant that rxReady is low exactly when a word is written.
  always @(negedge clk) begin
    if (bus.imemWE) obs_w.push_back({bus.imemAddr, bus.imemData});
    if (!rst && !prev_rst)
      check("ready_vs_we", 32'(bus.rxReady), 32'(!bus.imemWE));
  end

  // Frame-level reference: skip to sync, validate LEN, list writes, verify sum.
  task automatic model();
    int p;
    int len;
    logic [7:0] s;
    exp_w.delete();
    exp_ok  = 1'b0;
    exp_err = 1'b0;
    p = 0;
    while (p < fr.size() && fr[p] != 8'hA5) p++;
    p++;
    len = int'(fr[p]);
    p++;
    if (len == 0 || len > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    s = 8'h00;
    for (int i = 0; i < len; i++) begin
      exp_w.push_back({i[AW-1:0], fr[p], fr[p+1]});
      s = s + fr[p] + fr[p+1];
      p += 2;
    end
    if (fr[p] == s) exp_ok = 1'b1;
    else            exp_err = 1'b1;
  endtask

  task automatic build_frame(input int len, input bit bad, input int garbage);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    fr.delete();
    for (int i = 0; i < garbage; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      fr.push_back(b);
    end
    fr.push_back(8'hA5);
    fr.push_back(8'(len));
    for (int i = 0; i < 2 * len; i++) begin
      b = 8'($urandom);
      fr.push_back(b);
      s = s + b;
    end
    if (bad) s = s + 8'($urandom_range(1, 255));
    fr.push_back(s);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    bus.rxValid = 1'b1;
    bus.rxData  = b;
    while (!bus.rxReady && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("ready_timeout", 32'(bus.rxReady), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_frame(input bit hold);
    foreach (fr[i]) begin
      if (!hold) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int k = 0; k < gap; k++) begin
          bus.rxValid = 1'b0;
          bus.rxData  = 8'($urandom);
          @(negedge clk);
        end
      end
      send_byte(fr[i]);
    end
    bus.rxValid = 1'b0;
  endtask

  task automatic verify_frame(input string tag);
    model();
    check($sformatf("%s_nwr", tag), 32'(obs_w.size()), 32'(exp_w.size()));
    foreach (exp_w[i])
      if (i < obs_w.size())
        check($sformatf("%s_wr%0d", tag, i), 32'(obs_w[i]), 32'(exp_w[i]));
    check($sformatf("%s_ok", tag),     32'(loadOk),  32'(exp_ok));
    check($sformatf("%s_err", tag),    32'(loadErr), 32'(exp_err));
    check($sformatf("%s_cpurst", tag), 32'(cpuRst),  32'(!exp_ok));
    check($sformatf("%s_busy", tag),   32'(busy),    32'd0);
  endtask

  task automatic run(input string tag, input bit hold);
    obs_w.delete();
    send_frame(hold);
    repeat (2) @(negedge clk);
    verify_frame(tag);
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s_ready", tag),  32'(bus.rxReady),  32'd0);
    check($sformatf("%s_we", tag),     32'(bus.imemWE),   32'd0);
    check($sformatf("%s_addr", tag),   32'(bus.imemAddr), 32'd0);
    check($sformatf("%s_data", tag),   32'(bus.imemData), 32'd0);
    check($sformatf("%s_cpurst", tag), 32'(cpuRst),       32'd1);
    check($sformatf("%s_busy", tag),   32'(busy),         32'd0);
    check($sformatf("%s_ok", tag),     32'(loadOk),       32'd0);
    check($sformatf("%s_err", tag),    32'(loadErr),      32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst         = 1'b1;
    bus.rxValid = 1'b0;
    bus.rxData  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.rxReady), 32'd1);

    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h46};
    run("single", 1'b0);

    // Back-to-back: a frame of L words takes 3L+3 accepting cycles.
    fr = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'h01};
    obs_w.delete();
    c0 = cyc;
    send_frame(1'b1);
    check("b2b_cycles", 32'(cyc - c0), 32'd12);
    repeat (2) @(negedge clk);
    verify_frame("b2b");

    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47};
    run("badsum", 1'b0);
    send_byte(8'hA5);
    check("resync_err",    32'(loadErr), 32'd0);
    check("resync_cpurst", 32'(cpuRst),  32'd1);
    check("resync_busy",   32'(busy),    32'd1);
    send_byte(8'h00);
    bus.rxValid = 1'b0;
    @(negedge clk);
    check("len0_after_resync_err", 32'(loadErr), 32'd1);

    fr = '{8'hA5, 8'h00};
    run("len0", 1'b0);
    fr = '{8'hA5, 8'h81};
    run("len129", 1'b0);

    build_frame(128, 1'b0, 0);
    run("full", 1'b0);

    // Reload after success: garbage ignored, sync re-arms cpuRst at once.
    obs_w.delete();
    send_byte(8'h00);
    send_byte(8'h3C);
    send_byte(8'hFF);
    bus.rxValid = 1'b0;
    @(negedge clk);
    check("garbage_nwr", 32'(obs_w.size()), 32'd0);
    check("garbage_ok",  32'(loadOk),       32'd1);
    send_byte(8'hA5);
    check("reload_cpurst", 32'(cpuRst), 32'd1);
    check("reload_ok",     32'(loadOk), 32'd0);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h78);
    bus.rxValid = 1'b0;
    repeat (2) @(negedge clk);
    fr = '{8'h00, 8'h3C, 8'hFF, 8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h78};
    verify_frame("reload");

    // Reset mid-load after the first word has been written.
    obs_w.delete();
    fr = '{8'hA5, 8'h02, 8'h12, 8'h34};
    send_frame(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    check("midrst_nwr", 32'(obs_w.size()), 32'd1);
    if (obs_w.size() > 0) check("midrst_wr0", 32'(obs_w[0]), 32'h0001234);
    rst = 1'b0;
    @(negedge clk);
    build_frame(5, 1'b0, 0);
    run("after_rst", 1'b0);

    for (int n = 0; n < 8; n++) begin
      build_frame($urandom_range(1, 10), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      run($sformatf("rand%0d", n), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the toy CPU: receives a framed byte stream from a UART receiver over a valid/ready handshake, assembles big-endian 16-bit words, and writes them into the CPU instruction memory through a write port. It sits between the serial receiver and the instruction memory. It holds the processor in reset until a frame is received and its checksum verifies.

## Interface
- ADDR_WIDTH, 7, instruction memory address width; depth = 2^ADDR_WIDTH words (128)
- SYNC_BYTE, 8'hA5, frame start marker
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- rxData  input  8  received byte
- rxValid  input  1  rxData valid
- rxReady  output  1  loader accepts the byte this cycle; transfer = rxValid && rxReady
- imemWE  output  1  instruction memory write enable, one-cycle pulse per word
- imemAddr  output  ADDR_WIDTH  write address
- imemData  output  16  write data
- cpuRst  output  1  reset to the processor; high while no verified program is present
- busy  output  1  frame in progress (any state other than IDLE)
- loadOk  output  1  last frame verified; sticky until the next sync byte
- loadErr  output  1  last frame rejected; sticky until the next sync byte

## Operation
- Frame format: SYNC_BYTE, LEN (word count), LEN×(HI byte, LO byte), SUM. SUM = 8-bit modulo-256 sum of all data bytes; LEN is not included in SUM.
- FSM states: IDLE, LEN, HI, LO, WR, SUM.
- IDLE: rxReady=1. Non-sync bytes are accepted and discarded. SYNC_BYTE -> LEN. Sync clears loadOk and loadErr and sets cpuRst=1.
- LEN: the accepted byte sets the word count and clears the word index and the running sum.
  - LEN=0 or LEN>2^ADDR_WIDTH -> loadErr=1, go to IDLE.
  - Otherwise -> HI.
- HI: latch the byte into imemData[15:8], add it to the sum, go to LO.
- LO: latch the byte into imemData[7:0], add it to the sum, go to WR.
- WR: rxReady=0, imemWE=1, imemAddr = word index.
  - Increment the index.
  - If index+1 == LEN -> SUM, else -> HI.
- SUM: byte == running sum -> loadOk=1, cpuRst=0. Mismatch -> loadErr=1, cpuRst stays 1. Both cases go to IDLE.
- Inside a frame, SYNC_BYTE values are ordinary data; there is no resynchronisation mid-frame.
- Words already written by a failed frame remain in memory. cpuRst keeps the CPU from running them.
- The word index counts to 2^ADDR_WIDTH and needs ADDR_WIDTH+1 bits internally. imemAddr carries the low ADDR_WIDTH bits and never wraps within a valid frame.

## Timing
- Reset values: rxReady=0, imemWE=0, imemAddr=0, imemData=0, cpuRst=1, busy=0, loadOk=0, loadErr=0, state=IDLE.
- rxReady rises the first cycle after rst deasserts.
- All outputs are registered. State and flag updates appear the cycle after the accepting edge.
- imemWE is high for exactly one cycle, the cycle after the LO byte is accepted. imemAddr and imemData are stable in that cycle.
- Throughput: with rxValid held high, a word takes 3 cycles (HI, LO, WR bubble).
- cpuRst:
  - Falls the cycle after a correct SUM byte is accepted.
  - Rises the cycle after a SYNC_BYTE is accepted in IDLE.
- rst asserted mid-frame: the frame is abandoned and all outputs return to reset values. Memory contents are untouched.
- rxValid low stalls any state except WR indefinitely. There is no timeout.

## Test plan
- Single word: A5 01 12 34 46 -> one imemWE pulse, addr 0, data 16'h1234; loadOk=1, cpuRst=0, busy=0.
- Back-to-back, rxValid held high: A5 03 00 01 00 02 FF FF 01 -> writes 0:0001, 1:0002, 2:FFFF. rxReady is low exactly in each WR cycle. loadOk=1.
- Bad checksum: A5 01 12 34 47 -> addr 0 is still written with 1234; loadErr=1, cpuRst stays 1. A following A5 clears loadErr.
- Length bounds:
  - A5 00 -> loadErr=1, no write.
  - A5 81 -> loadErr=1, no write.
  - A5 80 plus 256 data bytes -> writes addresses 0..127.
- Reset mid-load: assert rst after A5 02 12 34 -> addr 0 written. All outputs return to reset values and the FSM is in IDLE. A following full frame loads correctly.
- Reload after success: a valid frame, then A5 -> cpuRst rises the next cycle and loadOk clears. Garbage bytes before A5 in IDLE are discarded with no write.
